// File: rtl/retire_ctrl_pkg.sv
// retire_ctrl_pkg: shared widths, ROB packet, physical register index and retire FSM states
package retire_ctrl_pkg;
  localparam int N = 3;
  localparam int NUM_SCALAR_BITS = 3;
  localparam int PHYS_REG_SZ_R10K = 64;
  typedef logic [$clog2(PHYS_REG_SZ_R10K)-1:0] PHYS_REG_IDX;
  typedef struct packed {
    PHYS_REG_IDX T_old;
    PHYS_REG_IDX T_new;
    logic        has_dest;
  } ROB_PACKET;
  typedef enum logic [1:0] {RUN, FLUSH, HALTED} RETIRE_STATE;
endpackage

// File: rtl/retire_ctrl_select.sv
// retire_select: eligible-prefix retire count, halt/mispredict truncation and freed-register mux
import retire_ctrl_pkg::*;
module retire_select (
  input  logic                       en,
  input  ROB_PACKET [N-1:0]          rob_outputs,
  input  logic [NUM_SCALAR_BITS-1:0] rob_outputs_valid,
  input  logic [N-1:0]               rob_mispred,
  input  logic [N-1:0]               rob_halt,
  input  logic [PHYS_REG_SZ_R10K-1:0] complete_list_exposed,
  output logic [NUM_SCALAR_BITS-1:0] num_retiring,
  output PHYS_REG_IDX [N-1:0]        phys_regs_retiring,
  output logic                       halt_hit,
  output logic                       mis_hit
);
  logic [NUM_SCALAR_BITS-1:0] vc;
  logic stop;
  // walk slots oldest first; stop at the first ineligible slot or just after a halt/mispredict
  always_comb begin
    vc = (rob_outputs_valid > NUM_SCALAR_BITS'(N)) ? NUM_SCALAR_BITS'(N) : rob_outputs_valid;
    num_retiring = '0;
    stop = 1'b0;
    halt_hit = 1'b0;
    mis_hit = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!stop && en && NUM_SCALAR_BITS'(i) < vc && complete_list_exposed[rob_outputs[i].T_new]) begin
        num_retiring = NUM_SCALAR_BITS'(i + 1);
        halt_hit = rob_halt[i];
        mis_hit = rob_mispred[i] && !rob_halt[i];
        stop = rob_halt[i] || rob_mispred[i];
      end else
        stop = 1'b1;
    end
    for (int i = 0; i < N; i++)
      phys_regs_retiring[i] = (NUM_SCALAR_BITS'(i) < num_retiring && rob_outputs[i].has_dest) ? rob_outputs[i].T_old : '0;
  end
endmodule

// File: rtl/retire_ctrl.sv
// retire_ctrl: retire FSM (RUN/FLUSH/HALTED) around retire_select; RETIRE_STATS_EN adds retire/stall counters
import retire_ctrl_pkg::*;
module retire_ctrl (
  input  logic                        clock,
  input  logic                        reset,
  input  ROB_PACKET [N-1:0]           rob_outputs,
  input  logic [NUM_SCALAR_BITS-1:0]  rob_outputs_valid,
  input  logic [N-1:0]                rob_mispred,
  input  logic [N-1:0]                rob_halt,
  input  logic [PHYS_REG_SZ_R10K-1:0] complete_list_exposed,
  output logic [NUM_SCALAR_BITS-1:0]  num_retiring,
  output PHYS_REG_IDX [N-1:0]         phys_regs_retiring,
  output logic                        flush,
`ifdef RETIRE_STATS_EN
  output logic [63:0]                 retired_count,
  output logic [31:0]                 stall_cycles,
`endif
  output logic                        halted
);
  RETIRE_STATE state, next;
  logic halt_hit, mis_hit;
  retire_select u_sel (
    .en                   (state == RUN),
    .rob_outputs          (rob_outputs),
    .rob_outputs_valid    (rob_outputs_valid),
    .rob_mispred          (rob_mispred),
    .rob_halt             (rob_halt),
    .complete_list_exposed(complete_list_exposed),
    .num_retiring         (num_retiring),
    .phys_regs_retiring   (phys_regs_retiring),
    .halt_hit             (halt_hit),
    .mis_hit              (mis_hit)
  );
  // halt beats mispredict; FLUSH lasts one cycle; HALTED holds until reset
  always_comb begin
    next = (state == RUN) ? (halt_hit ? HALTED : mis_hit ? FLUSH : RUN) :
           (state == FLUSH) ? RUN : HALTED;
  end
  // state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= RUN;
    else state <= next;
  end
  assign flush = state == FLUSH;
  assign halted = state == HALTED;
`ifdef RETIRE_STATS_EN
  // retire and stall statistics, frozen once halted
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      retired_count <= '0;
      stall_cycles <= '0;
    end else if (state != HALTED) begin
      retired_count <= retired_count + 64'(num_retiring);
      if (state == RUN && rob_outputs_valid != '0 && num_retiring == '0)
        stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif
endmodule

// File: doc/retire_ctrl.md
# retire_ctrl

Sequential controller wrapped around the commit datapath of the R10K out-of-order core. Each cycle it picks how many of the oldest ROB entries may retire and sends the matching physical registers to the freddylist. A retiring branch mispredict triggers a one-cycle pipeline flush, and a retiring halt stops commit permanently. It sits between the ROB head and the freddylist and replaces the purely combinational retire selection.

## Interface
Parameters (no module parameters; all widths come from the `sys_defs.svh` constants):
- `N`, no default, commit width; retire slots 0..N-1, slot 0 is the oldest.
- `NUM_SCALAR_BITS`, no default, width of the 0..N count fields.
- `PHYS_REG_SZ_R10K`, no default, physical register count.

Ports:
- `clock` in 1: the single clock.
- `reset` in 1: asynchronous, active-high reset.
- `rob_outputs` in `ROB_PACKET[N-1:0]`: ROB head entries (`T_old`, `T_new`, `has_dest`).
- `rob_outputs_valid` in `NUM_SCALAR_BITS`: number of valid head entries. Values above N are clamped to N.
- `rob_mispred` in N: slot i is a resolved mispredicted branch.
- `rob_halt` in N: slot i is a halt instruction.
- `complete_list_exposed` in `PHYS_REG_SZ_R10K`: completion bit per physical register.
- `num_retiring` out `NUM_SCALAR_BITS`: entries the ROB pops this cycle.
- `phys_regs_retiring` out `PHYS_REG_IDX[N-1:0]`: registers freed, one per slot.
- `flush` out 1: registered squash request to the front end, ROB and RS.
- `halted` out 1: registered; commit has stopped.

## Operation
- States: RUN, FLUSH, HALTED (`RETIRE_STATE` enum).
- Slot i is eligible when all of the following hold:
  - i < clamped valid count;
  - `complete_list_exposed[T_new]` = 1;
  - every slot j < i is eligible.
- Completion is checked on `T_new` regardless of `has_dest`.
- In RUN, `num_retiring` = length of the eligible prefix, cut just after (inclusive of) the first eligible slot with `rob_halt` or `rob_mispred` set.
- In FLUSH and HALTED, `num_retiring` = 0.
- `phys_regs_retiring[i]`, for i < `num_retiring`:
  - `T_old` when `has_dest` = 1;
  - 0 when `has_dest` = 0; the freddylist ignores register 0.
- Slots i >= `num_retiring` drive 0.
- State transitions:
  - RUN → HALTED when the last retiring slot has `rob_halt` set.
  - RUN → FLUSH when the last retiring slot has `rob_mispred` set.
  - FLUSH → RUN unconditionally.
  - HALTED is held until reset.
- If halt and mispredict are both set on the same slot, halt wins and no flush occurs.
- If mispredict is at slot i and halt at slot j > i, commit truncates at i and the halt is not retired.

## Timing
- `num_retiring` and `phys_regs_retiring` are combinational from the inputs and the current state (zero-cycle latency). The ROB pops on the next clock edge.
- `flush` = 1 exactly while state == FLUSH, i.e. one cycle, starting the cycle after the mispredict retires.
- `halted` = 1 from the cycle after the halt retires, until reset.
- Reset values: state RUN, `flush` 0, `halted` 0. Combinational outputs read 0 whenever their inputs give no eligible slot.
- Reset asserted mid-FLUSH or in HALTED forces RUN immediately (asynchronous); `flush` drops in the same cycle.
- Empty ROB (valid = 0) → `num_retiring` 0, no state change.
- Full width (valid = N, all complete, no events) → `num_retiring` = N.

## Configuration
- `RETIRE_STATS_EN` defined adds two outputs:
  - `retired_count` (64-bit): accumulates `num_retiring` each cycle;
  - `stall_cycles` (32-bit): increments when state == RUN, valid > 0 and `num_retiring` == 0.
- Both counters reset to 0, wrap on overflow and freeze in HALTED.
- Without the macro, the ports and counters do not exist and behaviour is otherwise identical.

## Structure
- `RETIRE_STATE` enum goes in `sys_defs.svh`, alongside `ROB_PACKET` and `PHYS_REG_IDX`.
- One sub-module, `retire_select`: combinational eligible-prefix, truncation and register-mux logic.
- `retire_ctrl` holds the FSM, the output registers and the optional counters.

## Test plan
All scenarios use `N` = 3.
- All complete, valid = 3, no events → `num_retiring` 3; `phys_regs_retiring` = each `T_old`; `flush` stays 0.
- Valid = 3, slot 1 `T_new` not complete → `num_retiring` 1; slots 1 and 2 output 0.
- Valid = 3, all complete, `rob_mispred` = 3'b010 → `num_retiring` 2; next cycle `flush` 1 and `num_retiring` 0; the cycle after, `flush` 0 and RUN resumes.
- `rob_halt` = 3'b001, valid = 3 → `num_retiring` 1; next cycle `halted` 1; later cycles with valid = 3 give `num_retiring` 0.
- `has_dest` = 0 on slot 0 with `T_old` = 7, valid = 1 → `phys_regs_retiring[0]` = 0. Separately, valid = 5 (clamped to 3) → `num_retiring` 3.
- Reset asserted during FLUSH → `flush` 0 immediately, state RUN. With `RETIRE_STATS_EN`, `retired_count` returns to 0.
